// File: rtl/multicycle_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer that owns every state-changing datapath strobe.
// Optional performance counters are built when PERF_COUNTER_EN is defined.
module multicycle_sequencer (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        dec_regwrite,
    input  logic        dec_memread,
    input  logic        dec_memwrite,
    input  logic        dec_mem2reg,
    input  logic        dec_branch,
    input  logic        dec_uncond_branch,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        halt_req,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        mem2reg,
    output logic [2:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   l_regwrite_q, l_memread_q, l_memwrite_q, l_mem2reg_q, l_branch_q, l_uncond_q;
    logic   l_regwrite_d, l_memread_d, l_memwrite_d, l_mem2reg_d, l_branch_d, l_uncond_d;
    logic   imem_req_s, ir_write_s, pc_write_s, pc_src_s;
    logic   dmem_req_s, dmem_we_s, reg_write_s, mem2reg_s;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q      <= S_IF;
            l_regwrite_q <= 1'b0;
            l_memread_q  <= 1'b0;
            l_memwrite_q <= 1'b0;
            l_mem2reg_q  <= 1'b0;
            l_branch_q   <= 1'b0;
            l_uncond_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            l_regwrite_q <= l_regwrite_d;
            l_memread_q  <= l_memread_d;
            l_memwrite_q <= l_memwrite_d;
            l_mem2reg_q  <= l_mem2reg_d;
            l_branch_q   <= l_branch_d;
            l_uncond_q   <= l_uncond_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        l_regwrite_d = l_regwrite_q;
        l_memread_d  = l_memread_q;
        l_memwrite_d = l_memwrite_q;
        l_mem2reg_d  = l_mem2reg_q;
        l_branch_d   = l_branch_q;
        l_uncond_d   = l_uncond_q;
        imem_req_s   = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        reg_write_s  = 1'b0;
        mem2reg_s    = 1'b0;
        case (state_q)
            S_IF: begin
                imem_req_s = 1'b1;
                if (imem_ack) begin
                    ir_write_s = 1'b1;
                    state_d    = S_ID;
                end
            end
            S_ID: begin
                l_regwrite_d = dec_regwrite;
                l_memread_d  = dec_memread;
                l_memwrite_d = dec_memwrite;
                l_mem2reg_d  = dec_mem2reg;
                l_branch_d   = dec_branch;
                l_uncond_d   = dec_uncond_branch;
                state_d      = S_EX;
            end
            S_EX: begin
                if (l_uncond_q) begin
                    pc_write_s = 1'b1;
                    pc_src_s   = 1'b1;
                end else if (l_branch_q) begin
                    pc_write_s = 1'b1;
                    pc_src_s   = zero;
                end else if (l_memwrite_q || l_memread_q) begin
                    state_d = S_MEM;
                end else if (l_regwrite_q) begin
                    state_d = S_WB;
                end else begin
                    pc_write_s = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = l_memwrite_q;
                if (dmem_ack) begin
                    if (l_memwrite_q) pc_write_s = 1'b1;
                    else              state_d    = S_WB;
                end
            end
            S_WB: begin
                reg_write_s = ~l_memwrite_q;
                mem2reg_s   = l_mem2reg_q;
                pc_write_s  = 1'b1;
            end
            S_HALT: begin
                if (!halt_req) state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // Every retire is a pc_write cycle; halt only takes effect on that boundary.
        if (pc_write_s) state_d = halt_req ? S_HALT : S_IF;
    end

    assign imem_req  = resetl & imem_req_s;
    assign ir_write  = resetl & ir_write_s;
    assign pc_write  = resetl & pc_write_s;
    assign pc_src    = resetl & pc_src_s;
    assign dmem_req  = resetl & dmem_req_s;
    assign dmem_we   = resetl & dmem_we_s;
    assign reg_write = resetl & reg_write_s;
    assign mem2reg   = resetl & mem2reg_s;
    assign state     = state_q;

`ifdef PERF_COUNTER_EN
    logic [31:0] cycle_count_q, cycle_count_d, instret_count_q, instret_count_d;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            cycle_count_q   <= 32'h0;
            instret_count_q <= 32'h0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    always_comb begin
        cycle_count_d   = cycle_count_q;
        instret_count_d = instret_count_q;
        if (state_q != S_HALT) cycle_count_d   = cycle_count_q + 32'd1;
        if (pc_write_s)        instret_count_d = instret_count_q + 32'd1;
    end

    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_count_q;
`else
    assign cycle_count   = 32'h0;
    assign instret_count = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks ADD/LDUR/STUR/CBZ/B/halt/reset scenarios.
module tb_multicycle_sequencer;

`ifdef PERF_COUNTER_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK, resetl;
    logic        dec_regwrite, dec_memread, dec_memwrite, dec_mem2reg, dec_branch, dec_uncond_branch;
    logic        zero, imem_ack, dmem_ack, halt_req;
    logic        imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write, mem2reg;
    logic [2:0]  state;
    logic [31:0] cycle_count, instret_count;
    logic [31:0] frozen;
    int          checks = 0;
    int          errors = 0;

    // {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write, mem2reg}
    wire [7:0] strb = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write, mem2reg};

    multicycle_sequencer dut (
        .CLK(CLK), .resetl(resetl),
        .dec_regwrite(dec_regwrite), .dec_memread(dec_memread), .dec_memwrite(dec_memwrite),
        .dec_mem2reg(dec_mem2reg), .dec_branch(dec_branch), .dec_uncond_branch(dec_uncond_branch),
        .zero(zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .halt_req(halt_req),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .mem2reg(mem2reg),
        .state(state), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at posedge+2; outputs sampled at posedge+6, then advance one cycle.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [7:0] eo);
        #4;
        chk({tag, "_state"}, {29'h0, state}, {29'h0, es});
        chk({tag, "_strb"}, {24'h0, strb}, {24'h0, eo});
        @(posedge CLK);
        #2;
    endtask

    task automatic set_dec(input logic rw, mr, mw, m2r, br, ub);
        dec_regwrite = rw; dec_memread = mr; dec_memwrite = mw;
        dec_mem2reg = m2r; dec_branch = br; dec_uncond_branch = ub;
    endtask

    initial begin
        resetl = 1'b0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_state", {29'h0, state}, 32'h0);
        chk("rst_strb", {24'h0, strb}, 32'h0);
        chk("rst_cyc", cycle_count, 32'h0);
        chk("rst_ret", instret_count, 32'h0);
        @(posedge CLK); #2;
        resetl = 1'b1;

        // ADD; dmem_ack held high is ignored outside MEM, dec_* dropped after ID is ignored
        set_dec(1, 0, 0, 0, 0, 0); imem_ack = 1'b1; dmem_ack = 1'b1;
        cyc("add_if", 3'd0, 8'b1100_0000);
        cyc("add_id", 3'd1, 8'b0000_0000);
        set_dec(0, 0, 0, 0, 0, 0);
        cyc("add_ex", 3'd2, 8'b0000_0000);
        cyc("add_wb", 3'd4, 8'b0010_0010);
        chk("add_cyc", cycle_count, PERF ? 32'd4 : 32'd0);
        chk("add_ret", instret_count, PERF ? 32'd1 : 32'd0);

        // LDUR with two dmem wait cycles
        set_dec(1, 1, 0, 1, 0, 0); dmem_ack = 1'b0;
        cyc("ld_if", 3'd0, 8'b1100_0000);
        cyc("ld_id", 3'd1, 8'b0000_0000);
        cyc("ld_ex", 3'd2, 8'b0000_0000);
        cyc("ld_mem0", 3'd3, 8'b0000_1000);
        cyc("ld_mem1", 3'd3, 8'b0000_1000);
        dmem_ack = 1'b1;
        cyc("ld_mem2", 3'd3, 8'b0000_1000);
        dmem_ack = 1'b0;
        cyc("ld_wb", 3'd4, 8'b0010_0011);

        // STUR with regwrite set, one imem wait and one dmem wait
        set_dec(1, 0, 1, 0, 0, 0); imem_ack = 1'b0;
        cyc("st_ifw", 3'd0, 8'b1000_0000);
        imem_ack = 1'b1;
        cyc("st_if", 3'd0, 8'b1100_0000);
        cyc("st_id", 3'd1, 8'b0000_0000);
        cyc("st_ex", 3'd2, 8'b0000_0000);
        cyc("st_memw", 3'd3, 8'b0000_1100);
        dmem_ack = 1'b1;
        cyc("st_mem", 3'd3, 8'b0010_1100);
        dmem_ack = 1'b0;

        // CBZ taken, CBZ not taken, B with branch also set and zero low
        set_dec(0, 0, 0, 0, 1, 0); zero = 1'b1;
        cyc("cbz1_if", 3'd0, 8'b1100_0000);
        cyc("cbz1_id", 3'd1, 8'b0000_0000);
        cyc("cbz1_ex", 3'd2, 8'b0011_0000);
        zero = 1'b0;
        cyc("cbz0_if", 3'd0, 8'b1100_0000);
        cyc("cbz0_id", 3'd1, 8'b0000_0000);
        cyc("cbz0_ex", 3'd2, 8'b0010_0000);
        set_dec(0, 0, 0, 0, 1, 1);
        cyc("b_if", 3'd0, 8'b1100_0000);
        cyc("b_id", 3'd1, 8'b0000_0000);
        cyc("b_ex", 3'd2, 8'b0011_0000);

        // ADD with halt_req raised in ID: completes, then halts with counters frozen
        set_dec(1, 0, 0, 0, 0, 0);
        cyc("h_if", 3'd0, 8'b1100_0000);
        halt_req = 1'b1;
        cyc("h_id", 3'd1, 8'b0000_0000);
        cyc("h_ex", 3'd2, 8'b0000_0000);
        cyc("h_wb", 3'd4, 8'b0010_0010);
        chk("h_cyc", cycle_count, PERF ? 32'd30 : 32'd0);
        chk("h_ret", instret_count, PERF ? 32'd7 : 32'd0);
        frozen = cycle_count;
        cyc("h_halt0", 3'd5, 8'b0000_0000);
        cyc("h_halt1", 3'd5, 8'b0000_0000);
        chk("h_frozen", cycle_count, frozen);
        halt_req = 1'b0;
        cyc("h_halt2", 3'd5, 8'b0000_0000);
        cyc("h_resume", 3'd0, 8'b1100_0000);

        // LDUR interrupted by reset while waiting in MEM
        set_dec(1, 1, 0, 1, 0, 0);
        cyc("r_id", 3'd1, 8'b0000_0000);
        cyc("r_ex", 3'd2, 8'b0000_0000);
        cyc("r_mem", 3'd3, 8'b0000_1000);
        resetl = 1'b0;
        #1;
        chk("r_state", {29'h0, state}, 32'h0);
        chk("r_strb", {24'h0, strb}, 32'h0);
        chk("r_cyc", cycle_count, 32'h0);
        chk("r_ret", instret_count, 32'h0);
        @(posedge CLK); #2;
        resetl = 1'b1; imem_ack = 1'b0;
        cyc("r_if", 3'd0, 8'b1000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
